// File: rtl/reflet_boot_pkg.sv
// Shared definitions for the Reflet boot sequencer and the bootloader ROM
// generator, so both agree on where the image lives and how long it is.
package reflet_boot_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    CAPTURE = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } boot_state_t;

  localparam logic [14:0] ROM_BASE_DEFAULT = 15'h7E00;
  localparam int          ROM_SIZE_DEFAULT = 434;

endpackage

// File: rtl/reflet_boot_rom_arbiter.sv
// Single ROM read port shared between the boot copy engine and the CPU.
// The CPU only gets the port once the copy is DONE, and loses it in the
// cycle a boot_req restarts the copy.
module reflet_boot_rom_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_done,
  input  logic        boot_req,
  input  logic [14:0] cpu_addr,
  input  logic        cpu_read,
  input  logic [14:0] copy_addr,
  input  logic        copy_enable,
  input  logic [7:0]  rom_data,
  output logic [14:0] rom_addr,
  output logic        rom_enable,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_wait
);

  logic cpu_grant;
  logic cpu_owned;

  // Port mux: CPU owns the ROM in DONE unless a restart is requested this cycle.
  always_comb begin
    cpu_grant    = in_done & ~boot_req;
    cpu_wait     = ~cpu_grant;
    rom_addr     = cpu_grant ? cpu_addr : copy_addr;
    rom_enable   = cpu_grant ? cpu_read : copy_enable;
    cpu_data_out = cpu_owned ? rom_data : 8'h00;
  end

  // Remember that the ROM output of the next cycle belongs to the CPU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cpu_owned <= 1'b0;
    else       cpu_owned <= cpu_grant & cpu_read;
  end

endmodule

// File: rtl/reflet_boot_sequencer.sv
// Reflet boot sequencer: copies the bootloader ROM into RAM while holding
// the core in reset, then hands the ROM read port to the CPU.
// Optional checksum check against EXPECTED_SUM: REFLET_BOOT_CHECKSUM_EN.
//
// state   | meaning
// FETCH   | ROM enabled at ROM_BASE+index
// CAPTURE | ROM byte latched into ram_data, added to checksum
// WRITE   | ram_write held until ram_ready, then next byte or DONE
// DONE    | CPU released (unless boot_error), CPU owns the ROM
module reflet_boot_sequencer
  import reflet_boot_pkg::*;
#(
  parameter logic [14:0] ROM_BASE     = ROM_BASE_DEFAULT,
  parameter int          ROM_SIZE     = ROM_SIZE_DEFAULT,
  parameter logic [15:0] DEST_BASE    = 16'h0000,
  parameter logic [15:0] EXPECTED_SUM = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        boot_req,
  input  logic [14:0] cpu_addr,
  input  logic        cpu_read,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_wait,
  output logic [14:0] rom_addr,
  output logic        rom_enable,
  input  logic [7:0]  rom_data,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        ram_write,
  input  logic        ram_ready,
  output logic        cpu_reset_out,
  output logic        done,
  output logic [15:0] checksum,
  output logic        boot_error
);

  localparam logic [8:0] LAST_INDEX = 9'(ROM_SIZE - 1);

  boot_state_t state;
  logic [8:0]  index;
  logic        copy_enable;
  logic [14:0] copy_addr;
  logic        sum_mismatch;

  // Copy-side ROM request; gated by reset so the port is idle while held.
  always_comb begin
    copy_enable = (state == FETCH) & ~reset;
    copy_addr   = copy_enable ? (ROM_BASE + {6'd0, index}) : 15'd0;
  end

`ifdef REFLET_BOOT_CHECKSUM_EN
  assign sum_mismatch = (checksum != EXPECTED_SUM);
`else
  localparam logic [15:0] unused_expected_sum = EXPECTED_SUM;
  assign sum_mismatch = 1'b0;
  assign boot_error   = 1'b0;
`endif

  // Copy FSM with registered RAM-side and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FETCH;
      index         <= 9'd0;
      ram_write     <= 1'b0;
      ram_addr      <= 16'h0000;
      ram_data      <= 8'h00;
      checksum      <= 16'h0000;
      done          <= 1'b0;
      cpu_reset_out <= 1'b1;
`ifdef REFLET_BOOT_CHECKSUM_EN
      boot_error    <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: state <= CAPTURE;
        CAPTURE: begin
          ram_data  <= rom_data;
          checksum  <= checksum + {8'd0, rom_data};
          ram_write <= 1'b1;
          ram_addr  <= DEST_BASE + {7'd0, index};
          state     <= WRITE;
        end
        WRITE: begin
          if (ram_ready) begin
            ram_write <= 1'b0;
            if (index == LAST_INDEX) begin
              state         <= DONE;
              done          <= 1'b1;
              cpu_reset_out <= sum_mismatch;
`ifdef REFLET_BOOT_CHECKSUM_EN
              boot_error    <= sum_mismatch;
`endif
            end else begin
              index <= index + 9'd1;
              state <= FETCH;
            end
          end
        end
        DONE: begin
          if (boot_req) begin
            state         <= FETCH;
            index         <= 9'd0;
            checksum      <= 16'h0000;
            done          <= 1'b0;
            cpu_reset_out <= 1'b1;
`ifdef REFLET_BOOT_CHECKSUM_EN
            boot_error    <= 1'b0;
`endif
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  reflet_boot_rom_arbiter u_arbiter (
    .clk          (clk),
    .reset        (reset),
    .in_done      (state == DONE),
    .boot_req     (boot_req),
    .cpu_addr     (cpu_addr),
    .cpu_read     (cpu_read),
    .copy_addr    (copy_addr),
    .copy_enable  (copy_enable),
    .rom_data     (rom_data),
    .rom_addr     (rom_addr),
    .rom_enable   (rom_enable),
    .cpu_data_out (cpu_data_out),
    .cpu_wait     (cpu_wait)
  );

endmodule

// File: doc/reflet_boot_sequencer.md
Name: reflet_boot_sequencer

Overview:
- Sequences the 434-byte bootloader ROM (bytes 0x7E00..0x7FB1, 1-cycle registered read latency, output forced to 0 when not enabled).
- After reset, copies the ROM image into RAM at DEST_BASE while holding the CPU in reset, then releases it.
- After the copy, arbitrates the single ROM read port between the copy engine and CPU reads.
- Sits between the Reflet core bus, the bootloader ROM and the RAM write port.

Parameters:
- ROM_BASE, 15'h7E00, first ROM byte address.
- ROM_SIZE, 434, bytes to copy, range 1..512.
- DEST_BASE, 16'h0000, first RAM destination address.
- EXPECTED_SUM, 16'h0000, golden checksum; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- boot_req  in  1  single-cycle pulse: restart the copy (honoured only in DONE)
- cpu_addr  in  15  CPU ROM read address
- cpu_read  in  1  CPU ROM read request
- cpu_data_out  out  8  CPU read data, valid 1 cycle after an accepted read
- cpu_wait  out  1  CPU must hold its request; ROM is owned by the copy engine
- rom_addr  out  15  to ROM addr
- rom_enable  out  1  to ROM enable
- rom_data  in  8  from ROM data_out
- ram_addr  out  16  RAM write address
- ram_data  out  8  RAM write data
- ram_write  out  1  RAM write strobe, held until ram_ready
- ram_ready  in  1  RAM accepted the write this cycle
- cpu_reset_out  out  1  holds the core in reset
- done  out  1  copy complete
- checksum  out  16  running byte sum
- boot_error  out  1  checksum mismatch

Behaviour:
- Reset values: cpu_reset_out=1, done=0, cpu_wait=1, rom_enable=0, ram_write=0, rom_addr=0, ram_addr=0, ram_data=0, checksum=0, boot_error=0, cpu_data_out=0; state=FETCH, index=0.
- States:
  - FETCH: rom_enable=1, rom_addr=ROM_BASE+index; next state CAPTURE.
  - CAPTURE: latch rom_data into ram_data; checksum += byte (16-bit wrap); next state WRITE.
  - WRITE: ram_write=1, ram_addr=DEST_BASE+index (16-bit wrap). On ram_ready: if index==ROM_SIZE-1, go to DONE; else index+1 and go to FETCH.
  - DONE: done=1, cpu_reset_out=0 (unless boot_error), cpu_wait=0.
- Per-byte timing: 3 cycles minimum; each extra cycle of ram_ready low adds one cycle. ram_write, ram_addr and ram_data stay stable while waiting.
- Arbitration:
  - Outside DONE: cpu_wait=1; the CPU request is ignored and never reaches the ROM.
  - In DONE: rom_addr=cpu_addr and rom_enable=cpu_read, combinationally.
  - A registered flag cpu_owned records that the CPU had the ROM last cycle; cpu_data_out = cpu_owned ? rom_data : 0.
- boot_req:
  - In DONE: next cycle goes to FETCH with index=0 and checksum=0; done=0, cpu_reset_out=1, boot_error=0.
  - Same cycle as cpu_read: the copy wins; cpu_wait=1 combinationally in that cycle and the CPU read is not issued.
  - Outside DONE: ignored.
- Reset mid-copy: immediate return to reset values; the copy restarts from index 0 once reset deasserts. Partially written RAM is simply overwritten.

Optional Feature:
- Macro: REFLET_BOOT_CHECKSUM_EN.
- Defined: on entry to DONE, compare checksum with EXPECTED_SUM. On mismatch, boot_error=1 and cpu_reset_out stays 1 until the next successful boot_req copy or reset. cpu_wait=0 still, so a debugger can read the ROM.
- Undefined: no comparator; boot_error tied to 0; checksum still reported.

Decomposition:
- Shared package:
  - state encoding constants (FETCH=2'd0, CAPTURE=2'd1, WRITE=2'd2, DONE=2'd3);
  - ROM_BASE and ROM_SIZE defaults, so the ROM generator and this block agree.
- One natural sub-module: reflet_boot_rom_arbiter. It holds the combinational mux and the cpu_owned register, with the FSM in the top.

Test Plan:
1. Reset release, ram_ready tied 1: 434 writes, ram_addr 0x0000..0x01B1. First byte 0x10, second 0x32, last 0x00. done and cpu_reset_out fall after 1302 cycles.
2. ram_ready low for 5 cycles on byte 3: write held with addr 0x0003 and data 0x31 stable; total extends by 5 cycles; no duplicate or skipped byte.
3. In DONE, cpu_read with cpu_addr 0x7E05: cpu_data_out=0x3C on the next cycle and cpu_wait=0. During the copy, cpu_read gives cpu_wait=1 and cpu_data_out=0.
4. boot_req in the same cycle as cpu_read in DONE: cpu_wait=1, copy restarts at index 0, checksum clears to 0, cpu_reset_out=1.
5. Reset asserted at index 200 during WRITE: outputs go to reset values immediately; after release, the copy restarts at ram_addr 0x0000.
6. With REFLET_BOOT_CHECKSUM_EN and EXPECTED_SUM wrong: boot_error=1, cpu_reset_out stays 1, done=1. With the correct sum: boot_error=0 and the CPU is released.
